fnd_scan_controller: RTL and testbench

Sequencing controller for the 4-digit FND path. Accepts a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble engine. Time-multiplexes the digits into the single-digit BCD-to-FND decoder by cycling the digit select, BCD value and enable at a fixed refresh rate. It sits between system logic, which supplies numbers, and the FND select/font decoder pair, which drives the display pins.

---
 rtl/fnd_scan_if.sv | 26 ++
 rtl/fnd_scan_controller.sv | 125 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Bundles the number-input handshake and the FND scan outputs of fnd_scan_controller.
// slave = the controller; master = system logic plus the display decoders.
interface fnd_scan_if;
    logic [13:0] i_value;
    logic        i_load;
    logic        i_blank_lz;
    logic        i_display_en;
    logic        o_busy;
    logic        o_overflow;
    logic [1:0]  o_digitSelect;
    logic [3:0]  o_bcd;
    logic        o_fnd_en;
    logic        o_dbg_state;

    // i_load is a single-cycle strobe, honoured only in a cycle where o_busy=0;
    // a strobe seen while o_busy=1 is dropped, never queued.
    modport slave (
        input  i_value, i_load, i_blank_lz, i_display_en,
        output o_busy, o_overflow, o_digitSelect, o_bcd, o_fnd_en, o_dbg_state
    );

    modport master (
        output i_value, i_load, i_blank_lz, i_display_en,
        input  o_busy, o_overflow, o_digitSelect, o_bcd, o_fnd_en, o_dbg_state
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD (sequential double-dabble) plus 4-digit time-multiplexed scan
// for a single-digit FND select/font decoder pair.
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    fnd_scan_if.slave    bus
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      state, state_next;
    logic [13:0] bin_sr, bin_next;
    logic [15:0] acc, acc_next, adj;
    logic [3:0]  cnt, cnt_next;
    logic [15:0] disp, disp_next;
    logic        ovf, ovf_next;
    logic        busy, busy_next;
    logic [29:0] shifted;

    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [3:0]    zero_from;
    logic [3:0]    blank;
    logic [1:0]    sel_q;
    logic [3:0]    bcd_q;
    logic          en_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
            disp   <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            bin_sr <= bin_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            disp   <= disp_next;
            ovf    <= ovf_next;
            busy   <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        bin_next   = bin_sr;
        acc_next   = acc;
        cnt_next   = cnt;
        disp_next  = disp;
        ovf_next   = ovf;
        adj        = acc;
        for (int n = 0; n < 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
        end
        shifted = {adj[14:0], bin_sr, 1'b0};

        case (state)
            IDLE: begin
                if (bus.i_load) begin
                    state_next = SHIFT;
                    bin_next   = (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;
                    acc_next   = '0;
                    cnt_next   = 4'd14;
                    ovf_next   = (bus.i_value > 14'd9999);
                end
            end
            SHIFT: begin
                acc_next = shifted[29:14];
                bin_next = shifted[13:0];
                cnt_next = cnt - 4'd1;
                // Display only takes the finished result, never a partial one.
                if (cnt == 4'd1) begin
                    disp_next  = shifted[29:14];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == SHIFT);
    end

    always_comb begin
        zero_from[3] = (disp[15:12] == 4'd0);
        zero_from[2] = zero_from[3] && (disp[11:8] == 4'd0);
        zero_from[1] = zero_from[2] && (disp[7:4] == 4'd0);
        zero_from[0] = zero_from[1] && (disp[3:0] == 4'd0);
        // The ones digit always lights so a zero value reads "0".
        blank = {zero_from[3:1], 1'b0} & {4{bus.i_blank_lz}};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tick  <= '0;
            idx   <= '0;
            sel_q <= '0;
            bcd_q <= '0;
            en_q  <= 1'b0;
        end else begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                idx  <= idx + 2'd1;
            end else begin
                tick <= tick + 1'b1;
            end
            sel_q <= idx;
            bcd_q <= disp[{idx, 2'b00} +: 4];
            en_q  <= bus.i_display_en & ~blank[idx];
        end
    end

    assign bus.o_busy        = busy;
    assign bus.o_overflow    = ovf;
    assign bus.o_digitSelect = sel_q;
    assign bus.o_bcd         = bcd_q;
    assign bus.o_fnd_en      = en_q;
    assign bus.o_dbg_state   = state;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed + randomized bench for fnd_scan_controller with SCAN_DIV=4, checked
// against a decimal-arithmetic model of the displayed number.
module tb_fnd_scan_controller;
    localparam int SCAN_DIV = 4;

    logic i_clk;
    logic i_reset_n;
    fnd_scan_if bus();

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: the displayed number as an integer plus pending conversion.
    int m_disp, m_pend, m_cnt, m_tick, m_idx;
    bit m_ovf;
    int p10[4] = '{1, 10, 100, 1000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = 0; m_pend = 0; m_cnt = 0; m_tick = 0; m_idx = 0; m_ovf = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 0);
        check({tag, "_ovf"},  32'(bus.o_overflow), 0);
        check({tag, "_sel"},  32'(bus.o_digitSelect), 0);
        check({tag, "_bcd"},  32'(bus.o_bcd), 0);
        check({tag, "_en"},   32'(bus.o_fnd_en), 0);
    endtask

    // One clock: expectation from pre-edge model state, model update, then compare.
    task automatic step();
        int e_sel, e_bcd, e_en;
        e_sel = m_idx;
        e_bcd = (m_disp / p10[m_idx]) % 10;
        e_en  = (bus.i_display_en && !(bus.i_blank_lz && m_idx > 0 && m_disp < p10[m_idx])) ? 1 : 0;
        if (m_cnt == 0) begin
            if (bus.i_load) begin
                m_pend = (bus.i_value > 9999) ? 9999 : int'(bus.i_value);
                m_ovf  = (bus.i_value > 9999);
                m_cnt  = 14;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_disp = m_pend;
        end
        m_tick = (m_tick + 1) % SCAN_DIV;
        if (m_tick == 0) m_idx = (m_idx + 1) % 4;
        @(posedge i_clk);
        #1;
        check("sel",  32'(bus.o_digitSelect), 32'(e_sel));
        check("bcd",  32'(bus.o_bcd), 32'(e_bcd));
        check("en",   32'(bus.o_fnd_en), 32'(e_en));
        check("busy", 32'(bus.o_busy), (m_cnt != 0) ? 1 : 0);
        check("ovf",  32'(bus.o_overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int value);
        bus.i_value = 14'(value);
        bus.i_load  = 1'b1;
        step();
        bus.i_load  = 1'b0;
    endtask

    // Loads a value and independently counts how long o_busy stays high.
    task automatic load_count_busy(input int value, input string tag);
        int busy_cycles;
        load(value);
        busy_cycles = 1;
        for (int i = 0; i < 40 && bus.o_busy === 1'b1; i++) begin
            step();
            if (bus.o_busy === 1'b1) busy_cycles++;
        end
        check(tag, 32'(busy_cycles), 14);
    endtask

    initial begin
        i_reset_n        = 1'b1;
        bus.i_value      = '0;
        bus.i_load       = 1'b0;
        bus.i_blank_lz   = 1'b0;
        bus.i_display_en = 1'b1;
        model_reset();
        #2;
        i_reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check_zero("rst_hold");
        end
        i_reset_n = 1'b1;

        // Free-running scan with an all-zero display, then dark.
        run(20);
        bus.i_display_en = 1'b0;
        run(8);
        bus.i_display_en = 1'b1;

        load_count_busy(1234, "busy_1234");
        run(2 * 4 * SCAN_DIV);

        load_count_busy(12000, "busy_12000");
        run(4 * SCAN_DIV + 2);
        load(5);
        run(14 + 4 * SCAN_DIV);

        // Leading-zero blanking on a single-digit value.
        load(7);
        bus.i_blank_lz = 1'b1;
        run(14 + 4 * SCAN_DIV);
        bus.i_blank_lz = 1'b0;
        run(4 * SCAN_DIV);

        // Load strobe during a conversion must be dropped.
        load(4321);
        run(5);
        bus.i_value = 14'd1111;
        bus.i_load  = 1'b1;
        step();
        bus.i_load  = 1'b0;
        run(10 + 4 * SCAN_DIV);
        load(0);
        bus.i_blank_lz = 1'b1;
        run(14 + 4 * SCAN_DIV);
        bus.i_blank_lz = 1'b0;

        // Reset in the middle of a conversion discards both old and new values.
        load(1234);
        run(14 + 2);
        load(9876);
        run(6);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(posedge i_clk);
        #1;
        check_zero("rst_mid_hold");
        i_reset_n = 1'b1;
        run(4 * SCAN_DIV + 3);

        // Randomized loads, blanking, enables and extra strobes.
        for (int r = 0; r < 40; r++) begin
            bus.i_blank_lz   = 1'($urandom_range(0, 1));
            bus.i_display_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                load(int'($urandom_range(9990, 16383)));
            else
                load(int'($urandom_range(0, 9999)));
            for (int k = 0; k < int'($urandom_range(3, 30)); k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.i_value = 14'($urandom_range(0, 16383));
                    bus.i_load  = 1'b1;
                end
                step();
                bus.i_load = 1'b0;
            end
        end
        run(20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
